// File: rtl/uart_boot_sender.sv
// Streams a boot image over an 8N1 UART line: header 0xA5, 16-bit length, the
// words (LSB first) fetched from a one-cycle-latency memory, then a byte checksum.
module uart_boot_sender #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_words,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        TX,
  output logic        busy,
  output logic        done
);

  // The read is issued three cycles before a byte ends, so FETCH and WAIT fill
  // the last two cycles of that byte's stop bit.
  localparam int unsigned TRIG_IDX  = 10 * CLKS_PER_BIT - 3;
  localparam logic [3:0]  TRIG_BIT  = 4'(TRIG_IDX / CLKS_PER_BIT);
  localparam logic [15:0] TRIG_BAUD = 16'(TRIG_IDX % CLKS_PER_BIT);
  localparam logic [15:0] LAST_BAUD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    IDLE, HDR, LEN0, LEN1, FETCH, WAIT, WBYTE, CSUM, FIN
  } frameState_t;

  frameState_t state;
  logic [15:0] baudCnt;
  logic [3:0]  bitIdx;
  logic [9:0]  shiftReg;
  logic [15:0] numWordsReg;
  logic [15:0] wordCnt;
  logic [1:0]  byteIdx;
  logic [31:0] wordReg;
  logic [7:0]  csum;

  logic bitEnd, byteEnd, preFetch;

  assign bitEnd   = (baudCnt == LAST_BAUD);
  assign byteEnd  = bitEnd && (bitIdx == 4'd9);
  assign preFetch = (bitIdx == TRIG_BIT) && (baudCnt == TRIG_BAUD);
  assign TX       = shiftReg[0];

  function automatic logic [9:0] frameOf(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  always_ff @(posedge CLK or negedge reset) begin
    // NOTE: every register here, the word buffer included, is cleared by the
    // async reset; shiftReg resets to all ones so TX goes idle-high at once.
    if (!reset) begin
      state       <= IDLE;
      baudCnt     <= '0;
      bitIdx      <= '0;
      shiftReg    <= '1;
      numWordsReg <= '0;
      wordCnt     <= '0;
      byteIdx     <= '0;
      wordReg     <= '0;
      csum        <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= BASE_ADDR;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      // Bit engine: free-running baud count, reloaded only at each bit boundary.
      if (busy) begin
        if (bitEnd) begin
          baudCnt <= '0;
          if (!byteEnd) begin
            bitIdx   <= bitIdx + 4'd1;
            shiftReg <= {1'b1, shiftReg[9:1]};
          end
        end else begin
          baudCnt <= baudCnt + 16'd1;
        end
      end

      // NOTE: the byte loads below are later non-blocking writes to the same
      // registers as the bit engine, so at a byte end they take precedence.
      case (state)
        IDLE, FIN: begin
          if (start) begin
            numWordsReg <= num_words;
            csum        <= '0;
            wordCnt     <= '0;
            busy        <= 1'b1;
            shiftReg    <= frameOf(8'hA5);
            bitIdx      <= '0;
            baudCnt     <= '0;
            state       <= HDR;
          end else begin
            state <= IDLE;
          end
        end
        HDR: if (byteEnd) begin
          shiftReg <= frameOf(numWordsReg[7:0]);
          bitIdx   <= '0;
          state    <= LEN0;
        end
        LEN0: if (byteEnd) begin
          shiftReg <= frameOf(numWordsReg[15:8]);
          bitIdx   <= '0;
          state    <= LEN1;
        end
        LEN1, WBYTE: begin
          if (state == WBYTE && byteIdx != 2'd3) begin
            if (byteEnd) begin
              shiftReg <= frameOf(wordReg[{byteIdx + 2'd1, 3'b000} +: 8]);
              bitIdx   <= '0;
              byteIdx  <= byteIdx + 2'd1;
            end
          end else if (preFetch && wordCnt != numWordsReg) begin
            rd_en   <= 1'b1;
            rd_addr <= BASE_ADDR + {14'd0, wordCnt, 2'b00};
            wordCnt <= wordCnt + 16'd1;
            state   <= FETCH;
          end else if (byteEnd) begin
            shiftReg <= frameOf(csum);
            bitIdx   <= '0;
            state    <= CSUM;
          end
        end
        FETCH: begin
          rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // WAIT always coincides with the final cycle of the previous stop bit.
          wordReg  <= rd_data;
          csum     <= csum + rd_data[7:0] + rd_data[15:8] + rd_data[23:16] + rd_data[31:24];
          shiftReg <= frameOf(rd_data[7:0]);
          bitIdx   <= '0;
          byteIdx  <= '0;
          state    <= WBYTE;
        end
        CSUM: if (byteEnd) begin
          shiftReg <= '1;
          bitIdx   <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
